// File: rtl/score_display_scheduler_if.sv
// Score/decoder bundle between game logic, the display scheduler and the shared 7-segment decoder.
// The master drives scores and the load strobe; the slave (scheduler) drives decoder and digit signals.
interface score_display_scheduler_if;
  logic [6:0] p1_score;
  logic [6:0] p2_score;
  logic       score_load;
  logic       score_busy;
  logic [3:0] dec_value;
  logic       dec_update;
  logic [3:0] digit_en;

  modport master (
    output p1_score, p2_score, score_load,
    input  score_busy, dec_value, dec_update, digit_en
  );

  modport slave (
    input  p1_score, p2_score, score_load,
    output score_busy, dec_value, dec_update, digit_en
  );
endinterface

// File: rtl/score_display_scheduler.sv
// Converts two 0-99 scores to BCD by repeated subtraction and scans them onto a
// 4-digit multiplexed display through one shared decoder, with blank guard time between digits.
module score_display_scheduler #(
  parameter int SHOW_CYCLES   = 50000,
  parameter int BLANK_CYCLES  = 4,
  parameter int LEAD_BLANK    = 1,
  parameter int DIGIT_ACT_LOW = 0
) (
  input logic                      clk,
  input logic                      reset,
  score_display_scheduler_if.slave bus
);
  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  logic [6:0] p1_rem, p2_rem, p1_rem_nxt, p2_rem_nxt;
  logic [3:0] p1_tens, p2_tens, p1_tens_nxt, p2_tens_nxt;
  logic       busy, done;
  logic [3:0] p1_t, p1_o, p2_t, p2_o;

  always_comb begin
    p1_rem_nxt  = p1_rem;
    p2_rem_nxt  = p2_rem;
    p1_tens_nxt = p1_tens;
    p2_tens_nxt = p2_tens;
    if (p1_rem >= 7'd10) begin
      p1_rem_nxt  = p1_rem - 7'd10;
      p1_tens_nxt = p1_tens + 4'd1;
    end
    if (p2_rem >= 7'd10) begin
      p2_rem_nxt  = p2_rem - 7'd10;
      p2_tens_nxt = p2_tens + 4'd1;
    end
    // Commit in the same cycle as the last subtraction so 99 takes exactly 9 busy cycles.
    done = (p1_rem_nxt < 7'd10) && (p2_rem_nxt < 7'd10);
  end

  always_ff @(posedge clk) begin
    if (bus.score_load) begin
      p1_rem  <= sat99(bus.p1_score);
      p2_rem  <= sat99(bus.p2_score);
      p1_tens <= 4'd0;
      p2_tens <= 4'd0;
    end else if (busy) begin
      p1_rem  <= p1_rem_nxt;
      p2_rem  <= p2_rem_nxt;
      p1_tens <= p1_tens_nxt;
      p2_tens <= p2_tens_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      p1_t <= 4'd0;
      p1_o <= 4'd0;
      p2_t <= 4'd0;
      p2_o <= 4'd0;
    end else if (bus.score_load) begin
      busy <= 1'b1;
    end else if (busy && done) begin
      busy <= 1'b0;
      p1_t <= p1_tens_nxt;
      p1_o <= p1_rem_nxt[3:0];
      p2_t <= p2_tens_nxt;
      p2_o <= p2_rem_nxt[3:0];
    end
  end

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [1:0]       slot;
  logic [3:0]       value_sel, en, dec_value, dec_update_unused_pad;
  logic             dec_update, suppress;

  assign dec_update_unused_pad = 4'd0;

  always_comb begin
    case (slot)
      2'd3:    value_sel = p1_t;
      2'd2:    value_sel = p1_o;
      2'd1:    value_sel = p2_t;
      default: value_sel = p2_o;
    endcase
  end

  // Odd slots are tens digits; the held decoder value decides suppression for the whole slot.
  assign suppress = (LEAD_BLANK != 0) && slot[0] && (dec_value == 4'd0);

  // Outputs are registered from the current phase, so the visible scan trails the FSM by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_BLANK;
      count      <= '0;
      slot       <= 2'd3;
      dec_update <= 1'b0;
      dec_value  <= 4'd0;
      en         <= 4'd0;
    end else begin
      dec_update <= (state == ST_BLANK) && (count == '0);
      if ((state == ST_BLANK) && (count == '0))
        dec_value <= value_sel;
      en <= ((state == ST_SHOW) && !suppress) ? (4'b0001 << slot) : 4'b0000;
      if (state == ST_BLANK) begin
        if (count == CNT_W'(BLANK_CYCLES - 1)) begin
          state <= ST_SHOW;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        if (count == CNT_W'(SHOW_CYCLES - 1)) begin
          state <= ST_BLANK;
          count <= '0;
          slot  <= slot - 2'd1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.score_busy = busy;
  assign bus.dec_value  = dec_value | dec_update_unused_pad;
  assign bus.dec_update = dec_update;
  assign bus.digit_en   = (DIGIT_ACT_LOW != 0) ? ~en : en;
endmodule

// File: tb/tb_score_display_scheduler.sv
// Scoreboard bench: stimulus pushes expected per-slot digits/enables, a negedge monitor
// pops and compares on every dec_update and watches blank/show enables each cycle.
module tb_score_display_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_display_scheduler_if intf ();

  score_display_scheduler #(
    .SHOW_CYCLES(8), .BLANK_CYCLES(2), .LEAD_BLANK(1), .DIGIT_ACT_LOW(0)
  ) dut (
    .clk(clk), .reset(rst), .bus(intf)
  );

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] value;
    logic [3:0] en;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0, upd_cnt = 0, frame_m = -1, slot_m = 3, since = 99, last_upd = 0;
  int have_exp = 0, prev_upd = 0;
  logic [3:0] exp_en, exp_val;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int f, input int s, input int v, input logic [3:0] e);
    exp_t x;
    x.frame = f; x.slot = s; x.value = 4'(v); x.en = e;
    q.push_back(x);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      upd_cnt = 0; frame_m = -1; since = 99; have_exp = 0; prev_upd = 0;
      check("reset_digit_en", int'(intf.digit_en), 0);
      check("reset_dec_update", int'(intf.dec_update), 0);
    end else begin
      if (intf.dec_update) begin
        check("update_width", prev_upd, 0);
        slot_m = 3 - (upd_cnt % 4);
        if (slot_m == 3) frame_m++;
        if (upd_cnt > 0) check("slot_period", cyc - last_upd, 10);
        last_upd = cyc; upd_cnt++; since = 0; have_exp = 0;
        while (q.size() > 0 && (q[0].frame < frame_m ||
               (q[0].frame == frame_m && q[0].slot > slot_m))) begin
          checks++; errors++;
          $display("FAIL missed_slot: frame %0d slot %0d value %0d never presented",
                   q[0].frame, q[0].slot, q[0].value);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].frame == frame_m && q[0].slot == slot_m) begin
          e = q.pop_front();
          check($sformatf("dec_value_f%0d_s%0d", frame_m, slot_m), int'(intf.dec_value), int'(e.value));
          have_exp = 1; exp_en = e.en; exp_val = e.value;
        end
      end else if (since < 99) begin
        since++;
      end
      check("digit_en_onehot0", int'($onehot0(intf.digit_en)), 1);
      if (since < 2)
        check("blank_digit_en", int'(intf.digit_en), 0);
      else if (since < 10 && have_exp != 0)
        check($sformatf("show_digit_en_s%0d", slot_m), int'(intf.digit_en), int'(exp_en));
      if (have_exp != 0 && since < 10)
        check("dec_value_hold", int'(intf.dec_value), int'(exp_val));
      prev_upd = int'(intf.dec_update);
    end
  end

  task automatic wait_frame_start(output int f);
    int found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk); #2;
      if (intf.dec_update && (upd_cnt % 4) == 0) found = 1;
    end
    if (found == 0) begin
      checks++; errors++;
      $display("FAIL frame_start: got no slot-3 update, expected one within 200 cycles");
    end
    f = frame_m + 1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (intf.score_busy && n < 20) begin
      n++;
      @(posedge clk); #2;
    end
  endtask

  task automatic load_scores(input int p1, input int p2, output int n);
    intf.p1_score = 7'(p1);
    intf.p2_score = 7'(p2);
    intf.score_load = 1'b1;
    @(posedge clk); #2;
    intf.score_load = 1'b0;
    count_busy(n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    check({name, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  task automatic push_frame(input int f, input int v3, input int v2, input int v1, input int v0,
                            input logic [3:0] e3, input logic [3:0] e1);
    push(f, 3, v3, e3);
    push(f, 2, v2, 4'b0100);
    push(f, 1, v1, e1);
    push(f, 0, v0, 4'b0001);
  endtask

  initial begin
    int f, n, found;
    intf.p1_score = 7'd0;
    intf.p2_score = 7'd0;
    intf.score_load = 1'b0;

    // Test 1: reset state and first frame of zeros
    repeat (3) @(posedge clk);
    #2;
    check("rst_digit_en", int'(intf.digit_en), 0);
    check("rst_dec_value", int'(intf.dec_value), 0);
    check("rst_dec_update", int'(intf.dec_update), 0);
    check("rst_score_busy", int'(intf.score_busy), 0);
    push_frame(0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #2;
    check("first_update_clk1", int'(intf.dec_update), 1);
    check("first_update_value", int'(intf.dec_value), 0);
    drain("t1");

    // Test 2: 42 / 7, visible from the next update onward
    wait_frame_start(f);
    load_scores(42, 7, n);
    check("t2_busy_cycles", n, 4);
    push(f, 2, 2, 4'b0100);
    push(f, 1, 0, 4'b0000);
    push(f, 0, 7, 4'b0001);
    push_frame(f + 1, 4, 2, 0, 7, 4'b1000, 4'b0000);
    drain("t2");

    // Test 3: saturation to 99
    wait_frame_start(f);
    load_scores(120, 99, n);
    check("t3_busy_cycles", n, 9);
    push_frame(f + 1, 9, 9, 9, 9, 4'b1000, 4'b0010);
    drain("t3");

    // Test 4: reload during conversion, latest wins
    wait_frame_start(f);
    intf.p1_score = 7'd42;
    intf.p2_score = 7'd7;
    intf.score_load = 1'b1;
    @(posedge clk); #2;
    intf.score_load = 1'b0;
    check("t4_busy_first", int'(intf.score_busy), 1);
    @(posedge clk); #2;
    intf.p1_score = 7'd15;
    intf.p2_score = 7'd30;
    intf.score_load = 1'b1;
    @(posedge clk); #2;
    intf.score_load = 1'b0;
    count_busy(n);
    check("t4_busy_after_reload", n, 3);
    push(f, 2, 5, 4'b0100);
    push(f, 1, 3, 4'b0010);
    push(f, 0, 0, 4'b0001);
    push_frame(f + 1, 1, 5, 3, 0, 4'b1000, 4'b0010);
    drain("t4");

    // Test 5: reset in the middle of slot 1 SHOW
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(posedge clk); #2;
      if (intf.digit_en == 4'b0010) found = 1;
    end
    check("t5_slot1_shown", found, 1);
    rst = 1'b1;
    #1;
    check("t5_en_drop_async", int'(intf.digit_en), 0);
    check("t5_dec_value_reset", int'(intf.dec_value), 0);
    check("t5_busy_reset", int'(intf.score_busy), 0);
    push_frame(0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    check("t5_restart_update", int'(intf.dec_update), 1);
    drain("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
